// File: rtl/rc4_crack_core_if.sv
// rc4_crack_core_if: control, status and memory-port bundle of the RC4 cracking core.
// master = the core; slave = the host plus the S RAM, message ROM and decrypted RAM.
interface rc4_crack_core_if #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned MSG_AW    = 5
);
  logic                   start;
  logic [KEY_BYTES*8-1:0] key_lo;
  logic [KEY_BYTES*8-1:0] key_hi;
  logic [7:0]             q_s;
  logic [7:0]             q_m;
  logic [7:0]             address_s;
  logic [7:0]             data_s;
  logic                   wren_s;
  logic [MSG_AW-1:0]      address_m;
  logic [MSG_AW-1:0]      address_d;
  logic [7:0]             data_d;
  logic                   wren_d;
  logic                   busy;
  logic                   cracked;
  logic                   failed;
  logic [KEY_BYTES*8-1:0] cur_key;

  modport master (
    input  start, key_lo, key_hi, q_s, q_m,
    output address_s, data_s, wren_s, address_m, address_d, data_d, wren_d,
    output busy, cracked, failed, cur_key
  );

  modport slave (
    output start, key_lo, key_hi, q_s, q_m,
    input  address_s, data_s, wren_s, address_m, address_d, data_d, wren_d,
    input  busy, cracked, failed, cur_key
  );
endinterface

// File: rtl/rc4_crack_core.sv
// rc4_crack_core: RC4 brute-force key search over [key_lo, key_hi] inclusive.
// Per key: S[i]=i, KSA, then decrypt MSG_LEN bytes; a key wins when every plaintext
// byte is a-z or space. All memories are synchronous-read (data one cycle after address).
// Build option RC4_EARLY_ABORT_EN: drop a key on its first invalid plaintext byte instead
// of decrypting the whole message; the search result is the same either way.
module rc4_crack_core #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned MSG_AW    = 5
) (
  input logic              clk,
  input logic              rst,
  rc4_crack_core_if.master bus_io
);
  localparam int unsigned       KW       = KEY_BYTES * 8;
  localparam int unsigned       KIW      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [MSG_AW-1:0] LastK    = MSG_AW'(MSG_LEN - 1);
  localparam logic [KIW-1:0]    LastKidx = KIW'(KEY_BYTES - 1);
`ifdef RC4_EARLY_ABORT_EN
  localparam bit EarlyAbort = 1'b1;
`else
  localparam bit EarlyAbort = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StInit,
    StKsaRdI, StKsaRdJ, StKsaWrI, StKsaWrJ,
    StPrgaRdI, StPrgaRdJ, StPrgaWrI, StPrgaWrJ, StPrgaRdF, StPrgaWrD,
    StNextKey, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [KIW-1:0]    kidx_q, kidx_d;
  logic              bad_q, bad_d, busy_q, busy_d, cracked_q, cracked_d, failed_q, failed_d;
  logic [KW-1:0]     cur_key_q, cur_key_d, key_hi_q, key_hi_d;

  logic [7:0]        kbyte, j_ksa, j_prga, pt_byte;
  logic              byte_ok, range_bad;
  logic [7:0]        addr_s, wdata_s, wdata_d;
  logic              we_s, we_d;
  logic [MSG_AW-1:0] addr_m, addr_d;

  // Key byte for the current KSA step; byte 0 is the most significant.
  always_comb begin
    kbyte = 8'h00;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIW'(b)) kbyte = cur_key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // q_s holds S[i] in the RdJ states, so the new j is formed straight from read data.
  assign j_ksa     = j_q + bus_io.q_s + kbyte;
  assign j_prga    = j_q + bus_io.q_s;
  assign pt_byte   = bus_io.q_s ^ bus_io.q_m;
  assign byte_ok   = (pt_byte == 8'h20) || ((pt_byte >= 8'h61) && (pt_byte <= 8'h7a));
  assign range_bad = bus_io.key_lo > bus_io.key_hi;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus_io.start) state_d = range_bad ? StDone : StInit;
      StInit:         if (i_q == 8'hff) state_d = StKsaRdI;
      StKsaRdI:       state_d = StKsaRdJ;
      StKsaRdJ:       state_d = StKsaWrI;
      StKsaWrI:       state_d = StKsaWrJ;
      StKsaWrJ:       state_d = (i_q == 8'hff) ? StPrgaRdI : StKsaRdI;
      StPrgaRdI:      state_d = StPrgaRdJ;
      StPrgaRdJ:      state_d = StPrgaWrI;
      StPrgaWrI:      state_d = StPrgaWrJ;
      StPrgaWrJ:      state_d = StPrgaRdF;
      StPrgaRdF:      state_d = StPrgaWrD;
      StPrgaWrD: begin
        if ((k_q == LastK) || (EarlyAbort && !byte_ok)) state_d = StNextKey;
        else                                             state_d = StPrgaRdI;
      end
      StNextKey: state_d = (!bad_q || (cur_key_q == key_hi_q)) ? StDone : StInit;
      default:   state_d = StIdle;
    endcase
  end

  // Memory-port outputs; everything idles at 0 outside its access cycle.
  always_comb begin
    addr_s  = 8'h00;
    wdata_s = 8'h00;
    we_s    = 1'b0;
    addr_m  = '0;
    addr_d  = '0;
    wdata_d = 8'h00;
    we_d    = 1'b0;
    unique case (state_q)
      StInit:    begin addr_s = i_q; wdata_s = i_q; we_s = 1'b1; end
      StKsaRdI:  addr_s = i_q;
      StKsaRdJ:  addr_s = j_ksa;
      StKsaWrI:  begin addr_s = i_q; wdata_s = bus_io.q_s; we_s = 1'b1; end
      StKsaWrJ:  begin addr_s = j_q; wdata_s = si_q; we_s = 1'b1; end
      StPrgaRdI: addr_s = i_q + 8'd1;
      StPrgaRdJ: addr_s = j_prga;
      StPrgaWrI: begin addr_s = i_q; wdata_s = bus_io.q_s; we_s = 1'b1; end
      StPrgaWrJ: begin addr_s = j_q; wdata_s = si_q; we_s = 1'b1; end
      // After the swap S[i]+S[j] equals old S[j] + old S[i].
      StPrgaRdF: begin addr_s = si_q + sj_q; addr_m = k_q; end
      StPrgaWrD: begin addr_d = k_q; wdata_d = pt_byte; we_d = 1'b1; end
      default: ;
    endcase
  end

  // Datapath next-state: loop counters, swap operands, verdict flags and the key.
  always_comb begin
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    kidx_d    = kidx_q;
    bad_d     = bad_q;
    busy_d    = busy_q;
    cracked_d = cracked_q;
    failed_d  = failed_q;
    cur_key_d = cur_key_q;
    key_hi_d  = key_hi_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          cur_key_d = bus_io.key_lo;
          key_hi_d  = bus_io.key_hi;
          cracked_d = 1'b0;
          failed_d  = range_bad;
          busy_d    = !range_bad;
          i_d       = 8'h00;
        end
      end
      StInit: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hff) begin
          j_d    = 8'h00;
          kidx_d = '0;
        end
      end
      StKsaRdJ: begin
        si_d = bus_io.q_s;
        j_d  = j_ksa;
      end
      StKsaWrJ: begin
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == LastKidx) ? '0 : kidx_q + KIW'(1);
        if (i_q == 8'hff) begin
          j_d   = 8'h00;
          k_d   = '0;
          bad_d = 1'b0;
        end
      end
      StPrgaRdI: i_d = i_q + 8'd1;
      StPrgaRdJ: begin
        si_d = bus_io.q_s;
        j_d  = j_prga;
      end
      StPrgaWrI: sj_d = bus_io.q_s;
      StPrgaWrD: begin
        k_d = k_q + MSG_AW'(1);
        if (!byte_ok) bad_d = 1'b1;
      end
      StNextKey: begin
        if (!bad_q) begin
          cracked_d = 1'b1;
          busy_d    = 1'b0;
        end else if (cur_key_q == key_hi_q) begin
          failed_d = 1'b1;
          busy_d   = 1'b0;
        end else begin
          cur_key_d = cur_key_q + KW'(1);
          i_d       = 8'h00;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q       <= 8'h00;
      j_q       <= 8'h00;
      si_q      <= 8'h00;
      sj_q      <= 8'h00;
      k_q       <= '0;
      kidx_q    <= '0;
      bad_q     <= 1'b0;
      busy_q    <= 1'b0;
      cracked_q <= 1'b0;
      failed_q  <= 1'b0;
      cur_key_q <= '0;
      key_hi_q  <= '0;
    end else begin
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      k_q       <= k_d;
      kidx_q    <= kidx_d;
      bad_q     <= bad_d;
      busy_q    <= busy_d;
      cracked_q <= cracked_d;
      failed_q  <= failed_d;
      cur_key_q <= cur_key_d;
      key_hi_q  <= key_hi_d;
    end
  end

  assign bus_io.address_s = addr_s;
  assign bus_io.data_s    = wdata_s;
  assign bus_io.wren_s    = we_s;
  assign bus_io.address_m = addr_m;
  assign bus_io.address_d = addr_d;
  assign bus_io.data_d    = wdata_d;
  assign bus_io.wren_d    = we_d;
  assign bus_io.busy      = busy_q;
  assign bus_io.cracked   = cracked_q;
  assign bus_io.failed    = failed_q;
  assign bus_io.cur_key   = cur_key_q;
endmodule

// File: tb/tb_rc4_crack_core.sv
// tb_rc4_crack_core: directed bench for rc4_crack_core with behavioural S RAM, message ROM
// and decrypted RAM. The ROM is filled from a software RC4 of a known sentence.
module tb_rc4_crack_core;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rc4_crack_core_if #(.KEY_BYTES(3), .MSG_AW(5)) rif ();

  rc4_crack_core #(.KEY_BYTES(3), .MSG_LEN(32), .MSG_AW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   s_mem [256];
  logic [7:0]   m_rom [32];
  logic [7:0]   d_mem [32];
  int           s_wr_cnt = 0;
  int           d_wr_cnt = 0;
  int           x_cnt    = 0;
  logic [255:0] pt_vec;

  // Synchronous-read memories, write at the edge where wren is high.
  always @(posedge clk) begin
    rif.q_s <= s_mem[rif.address_s];
    rif.q_m <= m_rom[rif.address_m];
    if (rif.wren_s) begin
      s_mem[rif.address_s] <= rif.data_s;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    if (rif.wren_d) begin
      d_mem[rif.address_d] <= rif.data_d;
      d_wr_cnt <= d_wr_cnt + 1;
    end
    if (rif.busy && $isunknown(rif.address_s)) x_cnt <= x_cnt + 1;
  end

  // Reference RC4 with key 00,02,49 encrypting pt_vec into the ROM.
  task automatic build_rom();
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, f;
    kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'h00; j = 8'h00;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      f = s[i] + s[j];
      m_rom[k] = pt_vec[8*(31-k) +: 8] ^ s[f];
    end
  endtask

  task automatic do_start(input logic [23:0] lo, input logic [23:0] hi);
    @(negedge clk);
    rif.key_lo = lo;
    rif.key_hi = hi;
    rif.start  = 1'b1;
    @(negedge clk);
    rif.start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!rif.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rif.busy, rif.cracked, rif.failed} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {rif.busy, rif.cracked, rif.failed});
    end
    checks++;
    if (rif.cur_key !== 24'h0) begin
      errors++;
      $display("FAIL reset_cur_key: got %h expected 000000", rif.cur_key);
    end
    checks++;
    if ({rif.wren_s, rif.wren_d, rif.address_s, rif.data_s, rif.address_m, rif.address_d,
         rif.data_d} !== 36'h0) begin
      errors++;
      $display("FAIL reset_mem_ports: got nonzero expected 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_crack();
    bit ok;
    int d0 = d_wr_cnt;
    do_start(24'h000240, 24'h00024f);
    wait_idle(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL crack_timeout: busy=1 expected 0"); end
    checks++;
    if ({rif.cracked, rif.failed} !== 2'b10) begin
      errors++;
      $display("FAIL crack_flags: got %b expected 10", {rif.cracked, rif.failed});
    end
    checks++;
    if (rif.cur_key !== 24'h000249) begin
      errors++;
      $display("FAIL crack_key: got %h expected 000249", rif.cur_key);
    end
    checks++;
`ifdef RC4_EARLY_ABORT_EN
    if ((d_wr_cnt - d0) >= 320 || (d_wr_cnt - d0) < 32) begin
      errors++;
      $display("FAIL crack_dwrites: got %0d expected 32..319", d_wr_cnt - d0);
    end
`else
    if ((d_wr_cnt - d0) != 320) begin
      errors++;
      $display("FAIL crack_dwrites: got %0d expected 320", d_wr_cnt - d0);
    end
`endif
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (d_mem[k] !== pt_vec[8*(31-k) +: 8]) begin
        errors++;
        $display("FAIL crack_plain[%0d]: got %h expected %h", k, d_mem[k], pt_vec[8*(31-k) +: 8]);
      end
    end
  endtask

  task automatic test_fail();
    bit ok;
    int d0 = d_wr_cnt;
    do_start(24'h000000, 24'h000003);
    wait_idle(10000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fail_timeout: busy=1 expected 0"); end
    checks++;
    if ({rif.cracked, rif.failed} !== 2'b01) begin
      errors++;
      $display("FAIL fail_flags: got %b expected 01", {rif.cracked, rif.failed});
    end
    checks++;
    if (rif.cur_key !== 24'h000003) begin
      errors++;
      $display("FAIL fail_key: got %h expected 000003", rif.cur_key);
    end
    checks++;
`ifdef RC4_EARLY_ABORT_EN
    if ((d_wr_cnt - d0) >= 128) begin
      errors++;
      $display("FAIL fail_dwrites: got %0d expected <128", d_wr_cnt - d0);
    end
`else
    if ((d_wr_cnt - d0) != 128) begin
      errors++;
      $display("FAIL fail_dwrites: got %0d expected 128", d_wr_cnt - d0);
    end
`endif
  endtask

  task automatic test_single_key();
    bit ok;
    int s0 = s_wr_cnt;
    int bad = 0;
    do_start(24'h000249, 24'h000249);
    checks++;
    if (rif.failed !== 1'b0) begin
      errors++;
      $display("FAIL single_clear_failed: got %b expected 0", rif.failed);
    end
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (s_wr_cnt - s0 == 256) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL single_init_timeout: writes %0d expected 256", s_wr_cnt - s0); end
    for (int n = 0; n < 256; n++) if (s_mem[n] !== n[7:0]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_init_identity: got %0d bad entries expected 0", bad);
    end
    wait_idle(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: busy=1 expected 0"); end
    checks++;
    if ({rif.cracked, rif.failed, rif.cur_key} !== {2'b10, 24'h000249}) begin
      errors++;
      $display("FAIL single_result: got %b %h expected 10 000249",
               {rif.cracked, rif.failed}, rif.cur_key);
    end
  endtask

  task automatic test_inverted_range();
    int s0 = s_wr_cnt;
    int d0 = d_wr_cnt;
    do_start(24'h000010, 24'h00000f);
    checks++;
    if ({rif.busy, rif.cracked, rif.failed} !== 3'b001) begin
      errors++;
      $display("FAIL inv_flags: got %b expected 001", {rif.busy, rif.cracked, rif.failed});
    end
    checks++;
    if (rif.cur_key !== 24'h000010) begin
      errors++;
      $display("FAIL inv_key: got %h expected 000010", rif.cur_key);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ((s_wr_cnt - s0) != 0 || (d_wr_cnt - d0) != 0) begin
      errors++;
      $display("FAIL inv_writes: got s=%0d d=%0d expected 0 0", s_wr_cnt - s0, d_wr_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_and_restart();
    bit ok;
    do_start(24'h000240, 24'h00024f);
    repeat (300) @(negedge clk);
    checks++;
    if (rif.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", rif.busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.busy, rif.cracked, rif.failed, rif.cur_key, rif.wren_s, rif.wren_d,
         rif.address_s, rif.data_s, rif.address_m, rif.address_d, rif.data_d} !== 63'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got nonzero expected 0 (cur_key=%h)", rif.cur_key);
    end
    rst = 1'b0;
    do_start(24'h000000, 24'h000003);
    repeat (50) @(negedge clk);
    do_start(24'h000005, 24'h000009);
    checks++;
    if ({rif.busy, rif.cur_key} !== {1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL restart_ignored: got busy=%b key=%h expected 1 000000", rif.busy, rif.cur_key);
    end
    wait_idle(10000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_timeout: busy=1 expected 0"); end
    checks++;
    if ({rif.cracked, rif.failed, rif.cur_key} !== {2'b01, 24'h000003}) begin
      errors++;
      $display("FAIL restart_result: got %b %h expected 01 000003",
               {rif.cracked, rif.failed}, rif.cur_key);
    end
  endtask

  task automatic test_key_wrap();
    bit ok;
    int x0 = x_cnt;
    do_start(24'hfffffe, 24'hffffff);
    wait_idle(6000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: busy=1 expected 0"); end
    repeat (5) @(negedge clk);
    checks++;
    if ({rif.busy, rif.cracked, rif.failed, rif.cur_key} !== {3'b001, 24'hffffff}) begin
      errors++;
      $display("FAIL wrap_result: got %b %h expected 001 ffffff",
               {rif.busy, rif.cracked, rif.failed}, rif.cur_key);
    end
    checks++;
    if (x_cnt != x0) begin
      errors++;
      $display("FAIL wrap_addr_x: got %0d unknown cycles expected 0", x_cnt - x0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    rif.start  = 1'b0;
    rif.key_lo = 24'h0;
    rif.key_hi = 24'h0;
    pt_vec     = "the quick brown fox jumps over a";
    build_rom();
    test_reset();
    test_crack();
    test_fail();
    test_single_key();
    test_inverted_range();
    test_reset_mid_and_restart();
    test_key_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
